// File: rtl/meduram_pkg.sv
// Shared types and helpers for the multi-port RAM port initiator.
package meduram_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 8;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned CNT_WIDTH      = 32;

    typedef struct packed {
        logic                      write;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
    } cmd_t;

    // Pointer width for a power-of-2 depth; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/meduram_rsp_fifo.sv
// Synchronous response FIFO; push and pop may share an edge, even when full.
module meduram_rsp_fifo
    import meduram_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned PTR_WIDTH = ptr_width(DEPTH);
    localparam int unsigned CNT_W     = PTR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    // Head is driven to zero when empty so the idle output is deterministic.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop))
        else $error("meduram_rsp_fifo: push while full without pop");

endmodule

// File: rtl/meduram_port_initiator.sv
// Valid/ready command-to-RAM-port initiator with in-order read responses.
// Optional perf counters (wr_count/rd_count) are built when MEDURAM_PERF_CNT_EN is defined.
module meduram_port_initiator
    import meduram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  wren,
    output logic [ADDR_WIDTH-1:0] wraddr,
    output logic [DATA_WIDTH-1:0] wrdata,
    output logic                  rden,
    output logic [ADDR_WIDTH-1:0] rdaddr,
    input  logic [DATA_WIDTH-1:0] rddata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data
`ifdef MEDURAM_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  wr_count,
    output logic [CNT_WIDTH-1:0]  rd_count
`endif
);

    localparam int unsigned CREDIT_WIDTH = ptr_width(RSP_DEPTH) + 1;

    logic [CREDIT_WIDTH-1:0] credit;
    logic [CREDIT_WIDTH-1:0] credit_nxt;
    logic [RD_LATENCY-1:0]   rd_pipe;
    logic                    wr_acc;
    logic                    rd_acc;
    logic                    rsp_pop;
    logic                    fifo_push;
    logic                    fifo_full;
    logic                    fifo_empty;

    // Credit covers reads in flight plus queued responses, so the FIFO never overflows.
    assign cmd_ready = cmd_write | (credit < CREDIT_WIDTH'(RSP_DEPTH));
    assign wr_acc    = cmd_valid & cmd_write;
    assign rd_acc    = cmd_valid & ~cmd_write & cmd_ready;
    assign rsp_valid = ~fifo_empty;
    assign rsp_pop   = rsp_valid & rsp_ready;
    assign fifo_push = rd_pipe[RD_LATENCY-1];

    always_comb begin
        credit_nxt = credit;
        if (rd_acc && !rsp_pop) begin
            credit_nxt = credit + CREDIT_WIDTH'(1);
        end else if (!rd_acc && rsp_pop) begin
            credit_nxt = credit - CREDIT_WIDTH'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            credit <= '0;
            wren   <= 1'b0;
            wraddr <= '0;
            wrdata <= '0;
            rden   <= 1'b0;
            rdaddr <= '0;
        end else begin
            credit <= credit_nxt;
            wren   <= wr_acc;
            rden   <= rd_acc;
            if (wr_acc) begin
                wraddr <= cmd_addr;
                wrdata <= cmd_data;
            end
            if (rd_acc) begin
                rdaddr <= cmd_addr;
            end
        end
    end

    // Valid bit follows rden through the RAM read latency; its tail marks rddata valid.
    if (RD_LATENCY > 1) begin : g_pipe_multi
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                rd_pipe <= '0;
            end else begin
                rd_pipe <= {rd_pipe[RD_LATENCY-2:0], rden};
            end
        end
    end else begin : g_pipe_single
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                rd_pipe <= '0;
            end else begin
                rd_pipe <= rden;
            end
        end
    end

    meduram_rsp_fifo #(
        .DEPTH      (RSP_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk       (aclk),
        .rst_n     (aresetn),
        .push      (fifo_push),
        .push_data (rddata),
        .pop       (rsp_pop),
        .pop_data  (rsp_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    a_credit_covers_fifo: assert property (@(posedge aclk) disable iff (!aresetn)
        fifo_full |-> (credit == CREDIT_WIDTH'(RSP_DEPTH)))
        else $error("meduram_port_initiator: FIFO full with spare credit");

`ifdef MEDURAM_PERF_CNT_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (wr_acc) begin
                wr_count <= wr_count + CNT_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_count <= rd_count + CNT_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_meduram_port_initiator.sv
// Scoreboard bench for meduram_port_initiator with a behavioural RAM and reference memory.
module tb_meduram_port_initiator;
    import meduram_pkg::*;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 32;
    localparam int unsigned RL    = 1;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [DW-1:0] data;
        int            acc_cyc;
        bit            strict;
    } exp_t;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          wren;
    logic [AW-1:0] wraddr;
    logic [DW-1:0] wrdata;
    logic          rden;
    logic [AW-1:0] rdaddr;
    logic [DW-1:0] rddata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
`ifdef MEDURAM_PERF_CNT_EN
    logic [31:0]   wr_count;
    logic [31:0]   rd_count;
`endif

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            n_rd_acc = 0;
    int            n_popped = 0;
    bit            pop_now = 1'b0;
    bit            strict = 1'b0;
    bit            ready_mode = 1'b0;
    bit            ready_val = 1'b0;
    bit            prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [31:0]   n_wr = '0;
    logic [31:0]   n_rd = '0;
    exp_t          exp_q[$];
    logic [DW-1:0] ram [256];
    logic [DW-1:0] ref_mem [256];

    meduram_port_initiator #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RD_LATENCY (RL),
        .RSP_DEPTH  (DEPTH)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .wren      (wren),
        .wraddr    (wraddr),
        .wrdata    (wrdata),
        .rden      (rden),
        .rdaddr    (rdaddr),
        .rddata    (rddata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
`ifdef MEDURAM_PERF_CNT_EN
        ,
        .wr_count  (wr_count),
        .rd_count  (rd_count)
`endif
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    // RAM with one-cycle registered read; writes commit at the edge sampling wren.
    always @(posedge aclk) begin
        if (wren) ram[wraddr] <= wrdata;
        if (rden) rddata <= ram[rdaddr];
    end

    always begin
        @(posedge aclk);
        #2;
        rsp_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_val;
    end

    // Response monitor: pops the scoreboard on every handshake.
    always @(negedge aclk) begin
        exp_t e;
        int   lat;
        pop_now = 1'b0;
        if (!aresetn) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                checks++;
                if (!rsp_valid || rsp_data !== prev_data) begin
                    errors++;
                    $display("FAIL rsp_stable: valid=%0b data=0x%0h, required valid=1 data=0x%0h",
                             rsp_valid, rsp_data, prev_data);
                end
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: data=0x%0h with no read outstanding", rsp_data);
                end else begin
                    e   = exp_q.pop_front();
                    lat = cyc - e.acc_cyc;
                    if (rsp_data !== e.data || lat < 3 || (e.strict && lat != 3)) begin
                        errors++;
                        $display("FAIL rsp_data: got 0x%0h latency %0d, required 0x%0h latency %s3",
                                 rsp_data, lat, e.data, e.strict ? "" : ">=");
                    end
                end
                n_popped++;
                pop_now = 1'b1;
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_data = rsp_data;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Present one command (called just after a rising edge) and hold it until accepted.
    task automatic send(input cmd_t c);
        int waited = 0;
        bit done = 1'b0;
        bit exp_rdy;
        cmd_valid = 1'b1;
        cmd_write = c.write;
        cmd_addr  = c.addr;
        cmd_data  = c.data;
        while (!done) begin
            @(negedge aclk);
            #1;
            exp_rdy = c.write || ((n_rd_acc - (n_popped - int'(pop_now))) < int'(DEPTH));
            checks++;
            if (cmd_ready !== exp_rdy) begin
                errors++;
                $display("FAIL cmd_ready: got %0b, required %0b (write=%0b addr=%0d)",
                         cmd_ready, exp_rdy, c.write, c.addr);
            end
            if (cmd_ready) begin
                if (c.write) begin
                    ref_mem[c.addr] = c.data;
                    n_wr++;
                end else begin
                    exp_q.push_back('{ref_mem[c.addr], cyc, strict});
                    n_rd_acc++;
                    n_rd++;
                end
                done = 1'b1;
            end else if (++waited > 40) begin
                errors++;
                $display("FAIL cmd_timeout: addr=%0d not accepted in 40 cycles, required acceptance", c.addr);
                done = 1'b1;
            end
            @(posedge aclk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        send('{write: 1'b1, addr: AW'(a), data: d});
    endtask

    task automatic rd(input int a);
        send('{write: 1'b0, addr: AW'(a), data: '0});
    endtask

    task automatic drain();
        int w = 0;
        ready_mode = 1'b0;
        ready_val  = 1'b1;
        while (exp_q.size() != 0 && w < 100) begin
            tick();
            w++;
        end
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
        end
        chk("rsp_idle", 32'(rsp_valid), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t c;
        aresetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        for (int i = 0; i < 256; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_wren", 32'(wren), 32'h0);
        chk("rst_rden", 32'(rden), 32'h0);
        chk("rst_wraddr", 32'(wraddr), 32'h0);
        chk("rst_wrdata", wrdata, 32'h0);
        chk("rst_rdaddr", 32'(rdaddr), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        @(negedge aclk);
        aresetn = 1'b1;
        ready_val = 1'b1;
        tick();

        // Write then read back with minimum latency.
        strict = 1'b1;
        wr(100, 32'hBEEF);
        rd(100);
        drain();

        // Back-to-back reads stream out with no bubbles.
        for (int i = 0; i < 4; i++) wr(i, 32'h10 + 32'(i));
        for (int i = 0; i < 4; i++) rd(i);
        drain();
        strict = 1'b0;

        // Credit exhaustion: writes still flow; one pop frees one read a cycle later.
        ready_val = 1'b0;
        tick();
        fork
            begin
                for (int i = 0; i < 4; i++) rd(i);
                wr(7, 32'hA);
                rd(4);
                rd(5);
                rd(7);
            end
            begin
                repeat (10) @(posedge aclk);
                #3 ready_val = 1'b1;
                @(posedge aclk);
                #3 ready_val = 1'b0;
                repeat (6) @(posedge aclk);
                ready_val = 1'b1;
            end
        join
        drain();

        // Reset with reads in flight and queued.
        ready_val = 1'b0;
        tick();
        rd(0);
        rd(1);
        rd(2);
        aresetn = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("midrst_rden", 32'(rden), 32'h0);
        exp_q.delete();
        n_rd_acc = 0;
        n_popped = 0;
        n_wr = '0;
        n_rd = '0;
        @(negedge aclk);
        #1 aresetn = 1'b1;
        tick();
        chk("postrst_rsp_valid", 32'(rsp_valid), 32'h0);
        rd(100);
        rd(1);
        rd(2);
        rd(3);
        drain();

        // Randomised traffic with random backpressure.
        ready_mode = 1'b1;
        for (int n = 0; n < 300; n++) begin
            c.write = 1'($urandom_range(0, 1));
            c.addr  = AW'($urandom_range(0, 7));
            c.data  = $urandom;
            send(c);
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain();

`ifdef MEDURAM_PERF_CNT_EN
        chk("wr_count", wr_count, n_wr);
        chk("rd_count", rd_count, n_rd);
        force dut.wr_count = 32'hFFFF_FFFF;
        tick();
        release dut.wr_count;
        n_wr = 32'hFFFF_FFFF;
        wr(9, 32'h5);
        chk("wr_count_wrap", wr_count, n_wr);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
